// File: rtl/a2d_seq.sv
// a2d_seq: sequences the shared SPI A2D converter.
//
// One request (nxt) runs a round over four channels in fixed order:
// left load cell, right load cell, steering pot, battery. Each channel costs
// two SPI transactions with the same command word. The converter returns the
// conversion for a channel during the second transaction.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   nxt        request a conversion round (level, sampled every cycle)
//   spi_wrt    one-cycle pulse that starts an SPI transaction
//   spi_cmd    command word, meaningful while spi_wrt is high
//   spi_done   one-cycle pulse from the SPI master, transaction complete
//   spi_rd     SPI read data, meaningful while spi_done is high
//   lft_ld     latest left load cell result
//   rght_ld    latest right load cell result
//   steer_pot  latest steering potentiometer result
//   batt       latest battery result
//   vld        one-cycle pulse, round complete (results form a coherent set)
//   busy       high from round start until return to IDLE
//   tmo_err    sticky flag, spi_done never arrived within TMO_CYC cycles
module a2d_seq #(
  parameter logic [2:0] LFT_CH   = 3'd0,
  parameter logic [2:0] RGHT_CH  = 3'd4,
  parameter logic [2:0] STEER_CH = 3'd5,
  parameter logic [2:0] BATT_CH  = 3'd6,
  parameter int         TMO_CYC  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        vld,
  output logic        busy,
  output logic        tmo_err
);

  localparam int TW = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CMD      = 3'd1;
  localparam logic [2:0] WAIT_CMD = 3'd2;
  localparam logic [2:0] GAP      = 3'd3;
  localparam logic [2:0] READ     = 3'd4;
  localparam logic [2:0] WAIT_RD  = 3'd5;

  logic [2:0]    state;
  logic [1:0]    ch_idx;
  logic          pending;
  logic [TW-1:0] timer;

  // The converter packs its 12-bit result in the low bits; the upper nibble
  // carries nothing useful for us.
  logic unused_rd_hi;
  assign unused_rd_hi = ^spi_rd[15:12];

  function automatic logic [2:0] ch_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    ch_sel = LFT_CH;
      2'd1:    ch_sel = RGHT_CH;
      2'd2:    ch_sel = STEER_CH;
      default: ch_sel = BATT_CH;
    endcase
  endfunction

  assign spi_wrt = (state == CMD) || (state == READ);
  assign spi_cmd = {2'b00, ch_sel(ch_idx), 11'h000};
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch_idx    <= 2'd0;
      pending   <= 1'b0;
      timer     <= '0;
      lft_ld    <= 12'd0;
      rght_ld   <= 12'd0;
      steer_pot <= 12'd0;
      batt      <= 12'd0;
      vld       <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      vld <= 1'b0;
      // A request arriving mid-round is remembered (one deep) and served
      // right after the return to IDLE.
      if (nxt && (state != IDLE))
        pending <= 1'b1;

      case (state)
        IDLE: begin
          if (nxt || pending) begin
            pending <= 1'b0;
            ch_idx  <= 2'd0;
            state   <= CMD;
          end
        end
        CMD: begin
          timer <= '0;
          state <= WAIT_CMD;
        end
        WAIT_CMD: begin
          // spi_done wins over a timeout that lands on the same edge.
          if (spi_done)
            state <= GAP;
          else if (timer == TMO_LAST) begin
            tmo_err <= 1'b1;
            state   <= IDLE;
          end else
            timer <= timer + 1'b1;
        end
        GAP: begin
          state <= READ;
        end
        READ: begin
          timer <= '0;
          state <= WAIT_RD;
        end
        WAIT_RD: begin
          if (spi_done) begin
            case (ch_idx)
              2'd0:    lft_ld    <= spi_rd[11:0];
              2'd1:    rght_ld   <= spi_rd[11:0];
              2'd2:    steer_pot <= spi_rd[11:0];
              default: batt      <= spi_rd[11:0];
            endcase
            if (ch_idx == 2'd3) begin
              vld   <= 1'b1;
              state <= IDLE;
            end else begin
              ch_idx <= ch_idx + 2'd1;
              state  <= CMD;
            end
          end else if (timer == TMO_LAST) begin
            // Abort without vld; results captured earlier this round stay.
            tmo_err <= 1'b1;
            state   <= IDLE;
          end else
            timer <= timer + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_seq.sv
// Bench for a2d_seq: directed rounds against a small SPI responder, with a
// scoreboard (expected command words and result sets) checked by a monitor.
module tb_a2d_seq;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst, nxt, spi_done;
  logic [15:0] spi_rd;
  logic        spi_wrt, vld, busy, tmo_err;
  logic [15:0] spi_cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;

  always #10 clk = ~clk;

  a2d_seq #(.TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .nxt(nxt),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
    .spi_done(spi_done), .spi_rd(spi_rd),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .vld(vld), .busy(busy), .tmo_err(tmo_err)
  );

  int cmp_n = 0;
  int err_n = 0;
  int wrt_cnt = 0;
  int vld_cnt = 0;
  logic [15:0] exp_cmd[$];
  logic [47:0] exp_res[$];
  logic        rst_q = 1'b1;
  logic [11:0] prev_batt = 12'd0;

  always @(posedge clk) rst_q <= rst;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SPI responder: done arrives dly cycles after wrt. First transaction of a
  // pair returns junk, second returns rd_tab[channel].
  logic [15:0] rd_tab [8];
  int          dly = 8;
  int          cnt = 0;
  logic        second = 1'b0;
  logic        hold_en = 1'b0;
  logic        gap_glitch = 1'b0;
  logic        glitch_next = 1'b0;
  logic        inj = 1'b0;
  logic [2:0]  pend_ch = 3'd0;
  logic        pend_second = 1'b0;

  initial begin
    spi_done = 1'b0;
    spi_rd   = 16'h0000;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (glitch_next || inj) begin
        spi_done    = 1'b1;
        spi_rd      = inj ? 16'h0DDD : 16'h0EEE;
        glitch_next = 1'b0;
        inj         = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          spi_done = 1'b1;
          spi_rd   = pend_second ? rd_tab[pend_ch] : 16'hFFFF;
          if (!pend_second && gap_glitch) glitch_next = 1'b1;
        end
      end
      if (spi_wrt) begin
        pend_ch     = spi_cmd[13:11];
        pend_second = second;
        second      = !second;
        if (!(hold_en && pend_second && pend_ch == 3'd4)) cnt = dly;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents spi_wrt or vld.
  initial begin
    forever begin
      @(negedge clk);
      if (spi_wrt) begin
        wrt_cnt++;
        if (exp_cmd.size() == 0) chk("wrt_expected", 48'(1), 48'(0));
        else chk("spi_cmd", 48'(spi_cmd), 48'(exp_cmd.pop_front()));
      end
      if (vld) begin
        vld_cnt++;
        if (exp_res.size() == 0) chk("vld_expected", 48'(1), 48'(0));
        else chk("results", {lft_ld, rght_ld, steer_pot, batt}, exp_res.pop_front());
      end
      if (batt !== prev_batt && !rst_q) chk("vld_with_batt", 48'(vld), 48'(1));
      prev_batt = batt;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic set_tab(input logic [15:0] l, r, s, b);
    rd_tab[0] = l; rd_tab[4] = r; rd_tab[5] = s; rd_tab[6] = b;
  endtask

  task automatic push_cmds(input int n);
    logic [15:0] seq [8];
    seq = '{16'h0000, 16'h0000, 16'h2000, 16'h2000,
            16'h2800, 16'h2800, 16'h3000, 16'h3000};
    for (int i = 0; i < n; i++) exp_cmd.push_back(seq[i]);
  endtask

  task automatic pulse_nxt();
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  task automatic wait_vld(input string nm);
    int n = 0;
    while (!vld && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 48'(vld), 48'(1));
  endtask

  // Counts spi_wrt pulses (including the current cycle) until n are seen.
  task automatic wait_wrts(input int n);
    int k = spi_wrt ? 1 : 0;
    int b = 0;
    while (k < n && b < 600) begin
      @(negedge clk);
      b++;
      if (spi_wrt) k++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    nxt = 1'b0;
    for (int i = 0; i < 8; i++) rd_tab[i] = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 48'({spi_wrt, busy, vld, tmo_err}), 48'(0));
    chk("reset_regs", {lft_ld, rght_ld, steer_pot, batt}, 48'(0));
    rst = 1'b0;
    second = 1'b0;
    @(negedge clk);

    // Round A: basic round, upper nibble of read data ignored.
    set_tab(16'hF123, 16'h0456, 16'h0789, 16'h0ABC);
    push_cmds(8);
    exp_res.push_back({12'h123, 12'h456, 12'h789, 12'hABC});
    pulse_nxt();
    chk("wrt_latency", 48'({spi_wrt, busy}), 48'(2'b11));
    wait_vld("vld_a");
    chk("busy_idle_a", 48'(busy), 48'(0));
    chk("tmo_a", 48'(tmo_err), 48'(0));

    // Rounds B and C: second request during B is held and served right after.
    repeat (3) @(negedge clk);
    set_tab(16'hA111, 16'hB222, 16'hC333, 16'hDDDD);
    push_cmds(8);
    push_cmds(8);
    exp_res.push_back({12'h111, 12'h222, 12'h333, 12'hDDD});
    exp_res.push_back({12'h111, 12'h222, 12'h333, 12'hDDD});
    pulse_nxt();
    wait_wrts(3);
    pulse_nxt();
    wait_vld("vld_b");
    chk("busy_idle_b", 48'(busy), 48'(0));
    @(negedge clk);
    chk("restart_wrt", 48'(spi_wrt), 48'(1));
    wait_vld("vld_c");

    // Done on the last allowed wait cycle, plus a stray done in GAP.
    repeat (3) @(negedge clk);
    dly = TMO;
    gap_glitch = 1'b1;
    set_tab(16'h0321, 16'h0654, 16'h0987, 16'h0CBA);
    push_cmds(8);
    exp_res.push_back({12'h321, 12'h654, 12'h987, 12'hCBA});
    pulse_nxt();
    wait_vld("vld_edge");
    chk("tmo_edge", 48'(tmo_err), 48'(0));
    gap_glitch = 1'b0;
    dly = 8;

    // Timeout on the right load cell read.
    repeat (3) @(negedge clk);
    set_tab(16'h5AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD);
    hold_en = 1'b1;
    push_cmds(4);
    pulse_nxt();
    wait_wrts(4);
    n = 0;
    while (!tmo_err && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", 48'(n), 48'(17));
    chk("tmo_ctrl", 48'({busy, vld, tmo_err}), 48'(3'b001));
    chk("tmo_regs", {lft_ld, rght_ld, steer_pot, batt},
        {12'hAAA, 12'h654, 12'h987, 12'hCBA});
    hold_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("tmo_sticky", 48'(tmo_err), 48'(1));

    // Recovery round after timeout; error stays set.
    set_tab(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    push_cmds(8);
    exp_res.push_back({12'h001, 12'h002, 12'h003, 12'h004});
    pulse_nxt();
    wait_vld("vld_recover");
    chk("tmo_after_round", 48'(tmo_err), 48'(1));

    // Stray done while idle changes nothing.
    repeat (3) @(negedge clk);
    inj = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_done_regs", {lft_ld, rght_ld, steer_pot, batt},
        {12'h001, 12'h002, 12'h003, 12'h004});
    chk("idle_done_busy", 48'(busy), 48'(0));

    // Reset while waiting on the steering read.
    set_tab(16'h0F0F, 16'h0E0E, 16'h0D0D, 16'h0C0C);
    push_cmds(6);
    pulse_nxt();
    wait_wrts(6);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ctrl", 48'({spi_wrt, busy, vld, tmo_err}), 48'(0));
    chk("rst_regs", {lft_ld, rght_ld, steer_pot, batt}, 48'(0));
    @(negedge clk);
    rst = 1'b0;
    second = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_regs", {lft_ld, rght_ld, steer_pot, batt}, 48'(0));
    chk("post_rst_busy", 48'(busy), 48'(0));

    // Fresh round after reset.
    set_tab(16'h0FED, 16'h0CBA, 16'h0987, 16'h0654);
    push_cmds(8);
    exp_res.push_back({12'hFED, 12'hCBA, 12'h987, 12'h654});
    pulse_nxt();
    wait_vld("vld_final");
    chk("tmo_final", 48'(tmo_err), 48'(0));
    repeat (3) @(negedge clk);

    chk("wrt_total", 48'(wrt_cnt), 48'(58));
    chk("vld_total", 48'(vld_cnt), 48'(6));
    chk("cmd_queue_left", 48'(exp_cmd.size()), 48'(0));
    chk("res_queue_left", 48'(exp_res.size()), 48'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
